spi_seq_master: RTL and testbench
=================================

SPI_SEQ_MASTER -- requirements
Module: spi_seq_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: SCK half-period in clk_in cycles; legal range 2..255.
REQ-002 SHALL have parameter SSEL_SETUP, default 4: clk_in cycles from SSEL fall to the start of the first SCK low phase; legal range 1..255.
REQ-003 SHALL have parameter SSEL_GAP, default 8: minimum clk_in cycles SSEL stays high between frames; legal range 1..255.
REQ-004 SHALL have port clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port tx_data  input  8  byte to transmit, MSB first.
REQ-007 SHALL have port tx_valid  input  1  tx_data valid.
REQ-008 SHALL have port tx_last  input  1  byte is the last of its frame; qualified by tx_valid.
REQ-009 SHALL have port tx_ready  output  1  byte accepted when tx_valid and tx_ready are both high at a clk_in edge.
REQ-010 SHALL have port rx_data  output  8  byte captured from MISO.
REQ-011 SHALL have port rx_valid  output  1  one-cycle strobe; rx_data valid.
REQ-012 SHALL have port SCK  output  1  SPI clock, mode 0, idle low.
REQ-013 SHALL have port MOSI  output  1  serial data out.
REQ-014 SHALL have port MISO  input  1  serial data in; sampled directly on SCK rise (no synchronizer).
REQ-015 SHALL have port SSEL  output  1  active-low slave select.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, SETUP, SHIFT, WAIT, HOLD, GAP; all outputs SHALL be registered.
REQ-018 IDLE: SSEL=1, SCK=0, tx_ready=1; on handshake, latch tx_data and tx_last, drive SSEL=0 and MOSI=tx_data[7] next cycle, then enter SETUP.
REQ-019 SETUP: hold SCK=0 for SSEL_SETUP cycles, then enter SHIFT.
REQ-020 SHIFT: each bit SHALL be CLK_DIV cycles SCK low followed by CLK_DIV cycles SCK high; byte time 16*CLK_DIV cycles (64 at default).
REQ-021 On each SCK rise, MISO SHALL be shifted into the rx shift register LSB-side; on each SCK fall except the 8th, MOSI SHALL advance to the next lower bit.
REQ-022 On the 8th SCK fall, rx_data SHALL load the 8 captured bits and rx_valid SHALL pulse high for exactly one cycle.
REQ-023 After the 8th fall: if the latched last flag is 0, enter WAIT; if 1, enter HOLD.
REQ-024 WAIT: SSEL=0, SCK=0, tx_ready=1, with no timeout; on handshake, latch the byte, set MOSI=bit7, and enter SHIFT at the start of a low phase.
REQ-025 HOLD: keep SSEL=0 and SCK=0 for CLK_DIV cycles, then set SSEL=1 and enter GAP.
REQ-026 GAP: SSEL=1 for SSEL_GAP cycles with tx_ready=0, then enter IDLE.
REQ-027 tx_ready SHALL be 0 in SETUP, SHIFT, HOLD, and GAP; tx_valid in those states SHALL be ignored, and tx_data and tx_last SHALL be sampled only on handshake.
REQ-028 SSEL SHALL fall only on exiting IDLE and rise only on exiting HOLD; SCK SHALL never toggle while SSEL=1.
REQ-029 Each frame SHALL produce exactly 8*N SCK rises for N accepted bytes.
REQ-030 Phase and bit counters SHALL be 8 bits and 3 bits; they SHALL never wrap mid-byte.

Reset
REQ-031 While rst=0, asynchronously: SSEL=1, SCK=0, MOSI=0, tx_ready=0, rx_valid=0, rx_data=0x00, busy=0, state=IDLE, all counters 0.
REQ-032 tx_ready SHALL rise on the first clk_in edge after rst deasserts.
REQ-033 Reset mid-frame SHALL abort the frame with no rx_valid pulse; the partially transmitted byte is discarded.

Verification
REQ-034 Send 0x77 with tx_last=1, MISO looped to MOSI -> MOSI at the 8 SCK rises = 0,1,1,1,0,1,1,1; exactly 8 rises; rx_data=0x77 with one rx_valid pulse; SSEL low for 1 frame.
REQ-035 Send 0x77,0x00,0x03 back-to-back, tx_last on the third -> SSEL stays low throughout; 24 SCK rises; 3 rx_valid pulses; SSEL rises CLK_DIV cycles after the 24th fall.
REQ-036 After the 1st byte of a frame, drop tx_valid for 200 cycles -> SSEL=0, SCK=0, tx_ready=1 throughout; the frame resumes correctly on the next byte.
REQ-037 Present two single-byte frames with tx_valid held high -> SSEL high for at least SSEL_GAP (8) cycles between frames; tx_ready=0 during the gap.
REQ-038 Assert rst=0 after the 4th SCK rise -> SSEL=1 and SCK=0 immediately; no rx_valid pulse; the next frame transmits normally.
REQ-039 Drive MISO constant 1 during byte 0x00 -> rx_data=0xFF; MOSI=0 at all 8 rises.

Source files
------------

// File: rtl/spi_seq_master.sv
`default_nettype none
// ============================================================================
//  Module      : spi_seq_master
//  Description : Byte-stream SPI master (mode 0) that keeps SSEL low across
//                consecutive bytes until a byte tagged "last" completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_seq_master #(
    parameter int CLK_DIV    = 4,
    parameter int SSEL_SETUP = 4,
    parameter int SSEL_GAP   = 8
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SSEL,
    output logic       busy
);

    localparam logic [7:0] c_div_last   = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_setup_last = 8'(SSEL_SETUP - 1);
    localparam logic [7:0] c_gap_last   = 8'(SSEL_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_tx_shift;
    logic [7:0]  r_rx_shift;
    logic        r_last;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 8'd0;
            r_bit      <= 3'd0;
            r_tx_shift <= 8'd0;
            r_rx_shift <= 8'd0;
            r_last     <= 1'b0;
            SSEL       <= 1'b1;
            SCK        <= 1'b0;
            MOSI       <= 1'b0;
            tx_ready   <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= 8'd0;
            busy       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        r_tx_shift <= tx_data;
                        r_last     <= tx_last;
                        MOSI       <= tx_data[7];
                        SSEL       <= 1'b0;
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        r_cnt      <= 8'd0;
                        r_state    <= ST_SETUP;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (r_cnt == c_setup_last) begin
                        r_cnt   <= 8'd0;
                        r_bit   <= 3'd0;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != c_div_last) begin
                        r_cnt <= r_cnt + 8'd1;
                    end else begin
                        r_cnt <= 8'd0;
                        if (!SCK) begin
                            // Rising edge: capture MISO alongside the SCK update.
                            SCK        <= 1'b1;
                            r_rx_shift <= {r_rx_shift[6:0], MISO};
                        end else begin
                            SCK <= 1'b0;
                            if (r_bit == 3'd7) begin
                                rx_data  <= r_rx_shift;
                                rx_valid <= 1'b1;
                                r_bit    <= 3'd0;
                                if (r_last) begin
                                    r_state <= ST_HOLD;
                                end else begin
                                    tx_ready <= 1'b1;
                                    r_state  <= ST_WAIT;
                                end
                            end else begin
                                r_bit      <= r_bit + 3'd1;
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                MOSI       <= r_tx_shift[6];
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    // Frame stays open indefinitely until the next byte arrives.
                    if (tx_valid && tx_ready) begin
                        r_tx_shift <= tx_data;
                        r_last     <= tx_last;
                        MOSI       <= tx_data[7];
                        tx_ready   <= 1'b0;
                        r_cnt      <= 8'd0;
                        r_bit      <= 3'd0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == c_div_last) begin
                        SSEL    <= 1'b1;
                        MOSI    <= 1'b0;
                        r_cnt   <= 8'd0;
                        r_state <= ST_GAP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == c_gap_last) begin
                        r_cnt    <= 8'd0;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_seq_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_seq_master
//  Description : Directed self-checking bench for spi_seq_master.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_seq_master;

    localparam int CLK_DIV = 4;

    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       SCK;
    logic       MOSI;
    logic       MISO;
    logic       SSEL;
    logic       busy;

    logic miso_loop = 1'b1;
    logic miso_val  = 1'b0;
    assign MISO = miso_loop ? MOSI : miso_val;

    spi_seq_master #(.CLK_DIV(CLK_DIV), .SSEL_SETUP(4), .SSEL_GAP(8)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_last (tx_last),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .SCK     (SCK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .SSEL    (SSEL),
        .busy    (busy)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    // Line monitor, sampled on the falling clk_in edge.
    int   cyc = 0, rises = 0, falls = 0, rx_pulses = 0;
    int   ssel_rises = 0, ssel_falls = 0, hi_len = 0, last_gap = 0;
    int   last_fall_cyc = 0, rise_cyc = 0, gap_ready_bad = 0, sck_bad = 0;
    logic p_sck = 1'b0, p_ssel = 1'b1;
    logic       mosi_q[$];
    logic [7:0] rx_q[$];

    always @(negedge clk_in) begin
        cyc <= cyc + 1;
        if (SCK && !p_sck) begin
            rises <= rises + 1;
            mosi_q.push_back(MOSI);
        end
        if (!SCK && p_sck) begin
            falls         <= falls + 1;
            last_fall_cyc <= cyc;
        end
        if (rx_valid) begin
            rx_pulses <= rx_pulses + 1;
            rx_q.push_back(rx_data);
        end
        if (SSEL && !p_ssel) begin
            ssel_rises <= ssel_rises + 1;
            rise_cyc   <= cyc;
            hi_len     <= 1;
        end else if (SSEL) begin
            hi_len <= hi_len + 1;
        end
        if (!SSEL && p_ssel) begin
            ssel_falls <= ssel_falls + 1;
            last_gap   <= hi_len;
        end
        if (SSEL && busy && tx_ready) gap_ready_bad <= gap_ready_bad + 1;
        if (SSEL && p_ssel && (SCK != p_sck)) sck_bad <= sck_bad + 1;
        p_sck  <= SCK;
        p_ssel <= SSEL;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mosi_bits(input int base, input int n);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = {v[30:0], mosi_q[base + i]};
        return v;
    endfunction

    // Presents one byte; must be called at a falling clk_in edge.
    task automatic send(input logic [7:0] d, input logic l);
        logic ok = 1'b0;
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        if (ok) @(posedge clk_in);
        #1 tx_valid = 1'b0;
        check("send_accept", {31'd0, ok}, 32'd1);
        @(negedge clk_in);
    endtask

    task automatic wait_idle(input string tag);
        logic done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_in);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk_in);
        check(tag, {31'd0, done}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
        $fatal(1, "watchdog");
    end

    int b_rise, b_rx, b_pulse, b_sr, b_sf;
    logic bad;

    task automatic snap();
        b_rise  = rises;
        b_rx    = rx_q.size();
        b_pulse = rx_pulses;
        b_sr    = ssel_rises;
        b_sf    = ssel_falls;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk_in);
        check("rst_ssel", {31'd0, SSEL}, 32'd1);
        check("rst_sck", {31'd0, SCK}, 32'd0);
        check("rst_mosi", {31'd0, MOSI}, 32'd0);
        check("rst_ready", {31'd0, tx_ready}, 32'd0);
        check("rst_rxv", {31'd0, rx_valid}, 32'd0);
        check("rst_rxdata", {24'd0, rx_data}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        @(negedge clk_in);
        check("ready_after_rst", {31'd0, tx_ready}, 32'd1);

        // Single byte 0x77 in loopback
        snap();
        send(8'h77, 1'b1);
        wait_idle("a_idle");
        check("a_rises", rises - b_rise, 8);
        check("a_mosi", mosi_bits(b_rise, 8), 32'h77);
        check("a_rxdata", {24'd0, rx_data}, 32'h77);
        check("a_pulses", rx_pulses - b_pulse, 1);
        check("a_ssel_falls", ssel_falls - b_sf, 1);
        check("a_ssel_rises", ssel_rises - b_sr, 1);

        // Three bytes back-to-back in one frame
        snap();
        send(8'h77, 1'b0);
        send(8'h00, 1'b0);
        send(8'h03, 1'b1);
        wait_idle("b_idle");
        check("b_rises", rises - b_rise, 24);
        check("b_mosi", mosi_bits(b_rise, 24), 32'h770003);
        check("b_pulses", rx_pulses - b_pulse, 3);
        check("b_rx0", {24'd0, rx_q[b_rx]}, 32'h77);
        check("b_rx1", {24'd0, rx_q[b_rx + 1]}, 32'h00);
        check("b_rx2", {24'd0, rx_q[b_rx + 2]}, 32'h03);
        check("b_ssel_falls", ssel_falls - b_sf, 1);
        check("b_ssel_rises", ssel_rises - b_sr, 1);
        check("b_hold_len", rise_cyc - last_fall_cyc, CLK_DIV);

        // Frame left open for 200 cycles between bytes
        snap();
        send(8'h81, 1'b0);
        for (int i = 0; i < 200 && rx_pulses == b_pulse; i++) @(negedge clk_in);
        check("c_first_pulse", rx_pulses - b_pulse, 1);
        bad = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (SSEL !== 1'b0 || SCK !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b1) bad = 1'b1;
        end
        check("c_wait_stable", {31'd0, bad}, 32'd0);
        send(8'h18, 1'b1);
        wait_idle("c_idle");
        check("c_rises", rises - b_rise, 16);
        check("c_rx0", {24'd0, rx_q[b_rx]}, 32'h81);
        check("c_rx1", {24'd0, rx_q[b_rx + 1]}, 32'h18);
        check("c_ssel_rises", ssel_rises - b_sr, 1);

        // Two single-byte frames with tx_valid held high
        snap();
        tx_data  = 8'hA5;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        for (int i = 0; i < 1000 && (ssel_falls - b_sf) < 2; i++) @(negedge clk_in);
        tx_valid = 1'b0;
        check("d_two_frames", ssel_falls - b_sf, 2);
        wait_idle("d_idle");
        check("d_pulses", rx_pulses - b_pulse, 2);
        check("d_rx1", {24'd0, rx_q[b_rx + 1]}, 32'hA5);
        check("d_gap_min", {31'd0, last_gap >= 8}, 32'd1);
        check("d_gap_ready", gap_ready_bad, 0);

        // Reset after the 4th SCK rise aborts the frame
        snap();
        tx_data  = 8'h5A;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        @(negedge clk_in);
        tx_valid = 1'b0;
        for (int i = 0; i < 500 && (rises - b_rise) < 4; i++) @(negedge clk_in);
        check("e_four_rises", rises - b_rise, 4);
        rst = 1'b0;
        #1;
        check("e_ssel", {31'd0, SSEL}, 32'd1);
        check("e_sck", {31'd0, SCK}, 32'd0);
        check("e_busy", {31'd0, busy}, 32'd0);
        check("e_ready", {31'd0, tx_ready}, 32'd0);
        check("e_rxdata", {24'd0, rx_data}, 32'h00);
        repeat (3) @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        check("e_ready_rise", {31'd0, tx_ready}, 32'd1);
        check("e_no_pulse", rx_pulses - b_pulse, 0);
        snap();
        send(8'h3C, 1'b1);
        wait_idle("e_idle");
        check("e_rises", rises - b_rise, 8);
        check("e_rx", {24'd0, rx_q[b_rx]}, 32'h3C);

        // MISO held high while sending 0x00
        snap();
        miso_loop = 1'b0;
        miso_val  = 1'b1;
        send(8'h00, 1'b1);
        wait_idle("f_idle");
        check("f_rxdata", {24'd0, rx_data}, 32'hFF);
        check("f_mosi", mosi_bits(b_rise, 8), 32'h00);
        check("f_rises", rises - b_rise, 8);
        check("sck_quiet_when_deselected", sck_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
